arctan_cordic_ctrl: RTL and testbench

ARCTAN_CORDIC_CTRL -- requirements
Module: arctan_cordic_ctrl

---
 rtl/arctan_cordic_ctrl.sv | 116 +++++++++++
 tb/tb_arctan_cordic_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/arctan_cordic_ctrl.sv
// arctan_cordic_ctrl: multi-cycle CORDIC vectoring engine returning atan2(y,x) in Q16.16 degrees
module arctan_cordic_ctrl #(
    parameter int ITER  = 24,
    parameter int AFRAC = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] x_in,
    input  logic [31:0] y_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] theta
);
    localparam int ZW = 9 + AFRAC;
    localparam int IW = $clog2(ITER);
    localparam real PI = 3.14159265358979323846;
    localparam logic signed [ZW-1:0] Z90 = ZW'(64'sd90 <<< AFRAC);
    localparam logic signed [ZW-1:0] ZHALF = ZW'(64'sd1 <<< (AFRAC - 17));
    localparam logic signed [31:0] TMAX = 32'sd11796480;

    typedef enum logic [1:0] {S_IDLE, S_PRE, S_ITER, S_OUT} state_t;

    // atan(2^-k) in degrees scaled by 2^AFRAC, rounded to nearest at elaboration
    function automatic logic signed [ZW-1:0] atan_deg(input int k);
        return ZW'(longint'($atan(2.0 ** (-k)) * 180.0 / PI * (2.0 ** AFRAC)));
    endfunction

    logic signed [ZW-1:0] w_rom [ITER];
    genvar g;
    generate
        for (g = 0; g < ITER; g++) begin : g_rom
            assign w_rom[g] = atan_deg(g);
        end
    endgenerate

    state_t               r_state;
    logic signed [34:0]   r_x, r_y;
    logic signed [ZW-1:0] r_z;
    logic [IW-1:0]        r_i;
    logic                 r_zero, r_busy, r_done;
    logic [31:0]          r_theta;

    logic signed [34:0]   w_fx, w_fy, w_mag, w_xs, w_ys;
    logic signed [ZW-1:0] w_fz, w_rnd;
    logic signed [31:0]   w_th, w_out;
    logic [4:0]           w_msb, w_sh;

    // Fold into the right half-plane, then normalise so small operands keep full precision
    always_comb begin
        w_fx  = !r_x[34] ? r_x : (r_y[34] ? -r_y : r_y);
        w_fy  = !r_x[34] ? r_y : (r_y[34] ? r_x : -r_x);
        w_fz  = !r_x[34] ? '0 : (r_y[34] ? -Z90 : Z90);
        w_mag = w_fx | (w_fy[34] ? -w_fy : w_fy);
        w_msb = '0;
        for (int k = 0; k < 32; k++) w_msb = w_mag[k] ? 5'(k) : w_msb;
        w_sh  = 5'd31 - w_msb;
        w_xs  = r_x >>> r_i;
        w_ys  = r_y >>> r_i;
        w_rnd = r_z + ZHALF;
        w_th  = 32'(w_rnd >>> (AFRAC - 16));
        w_out = (w_th > TMAX) ? TMAX : (w_th <= -TMAX) ? -TMAX + 32'sd1 : w_th;
    end

    // Request FSM: latch, fold, ITER micro-rotations, round and publish
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_i     <= '0;
            r_zero  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_theta <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_x     <= {{3{x_in[31]}}, x_in};
                        r_y     <= {{3{y_in[31]}}, y_in};
                        r_zero  <= (x_in == '0) && (y_in == '0);
                        r_busy  <= 1'b1;
                        r_state <= S_PRE;
                    end
                end
                S_PRE: begin
                    r_x     <= w_fx <<< w_sh;
                    r_y     <= w_fy <<< w_sh;
                    r_z     <= w_fz;
                    r_i     <= '0;
                    r_state <= S_ITER;
                end
                S_ITER: begin
                    r_x     <= r_y[34] ? r_x - w_ys : r_x + w_ys;
                    r_y     <= r_y[34] ? r_y + w_xs : r_y - w_xs;
                    r_z     <= r_y[34] ? r_z - w_rom[r_i] : r_z + w_rom[r_i];
                    r_i     <= r_i + 1'b1;
                    r_state <= (r_i == IW'(ITER - 1)) ? S_OUT : S_ITER;
                end
                default: begin
                    r_theta <= r_zero ? '0 : w_out;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign theta = r_theta;
endmodule

// File: tb/tb_arctan_cordic_ctrl.sv
// tb_arctan_cordic_ctrl: scoreboard bench comparing the CORDIC engine against real-valued atan2
module tb_arctan_cordic_ctrl;
    localparam int ITER = 24;
    localparam real PI = 3.14159265358979323846;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] x_in = '0;
    logic [31:0] y_in = '0;
    logic        busy, done;
    logic [31:0] theta;

    arctan_cordic_ctrl #(.ITER(ITER), .AFRAC(24)) dut (
        .clk(clk), .rst(rst), .start(start), .x_in(x_in), .y_in(y_in),
        .busy(busy), .done(done), .theta(theta)
    );

    always #5 clk = ~clk;

    typedef struct {
        real ang;
        bit  zero;
        int  due;
    } exp_t;

    exp_t        q[$];
    exp_t        m_e;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [31:0] held = '0;
    real         diff;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic real ref_q16(input logic [31:0] x, input logic [31:0] y);
        return $atan2($itor($signed(y)), $itor($signed(x))) * 180.0 / PI * 65536.0;
    endfunction

    // Monitor: every completion is matched against the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst) begin
            total++;
            if (busy && done) begin
                bad++;
                $display("FAIL busy_done_overlap busy=%0b done=%0b required never both 1", busy, done);
            end
            if (done) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_done theta=%0d required no completion", $signed(theta));
                end else begin
                    m_e = q.pop_front();
                    total++;
                    if (cyc != m_e.due) begin
                        bad++;
                        $display("FAIL latency done_edge=%0d required=%0d", cyc, m_e.due);
                    end
                    if (m_e.zero) begin
                        if (theta != '0) begin
                            bad++;
                            $display("FAIL theta_zero actual=%0d required=0", $signed(theta));
                        end
                    end else begin
                        diff = $itor($signed(theta)) - m_e.ang;
                        if (diff < 0.0) diff = -diff;
                        if (diff > 10.0 || $signed(theta) <= -32'sd11796480 || $signed(theta) > 32'sd11796480) begin
                            bad++;
                            $display("FAIL theta actual=%0d required=%0.2f+/-10 in (-11796480,11796480]",
                                     $signed(theta), m_e.ang);
                        end
                    end
                    held = theta;
                end
            end else if (theta !== held) begin
                bad++;
                $display("FAIL theta_hold actual=%0d required=%0d", $signed(theta), $signed(held));
            end
        end
    end

    // One cycle of stimulus; a start seen while not busy is a request the spec says is accepted
    task automatic drive(input bit s, input logic [31:0] x, input logic [31:0] y);
        start = s;
        x_in  = x;
        y_in  = y;
        if (s && !busy)
            q.push_back('{ang: ref_q16(x, y), zero: (x == '0 && y == '0), due: cyc + 1 + ITER + 2});
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            drive(1'b0, $urandom, $urandom);
            n++;
        end
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL timeout pending=%0d required=0", q.size());
            q.delete();
        end
        drive(1'b0, $urandom, $urandom);
    endtask

    task automatic run(input logic [31:0] x, input logic [31:0] y);
        drive(1'b1, x, y);
        wait_idle();
    endtask

    task automatic gen(output logic [31:0] x, output logic [31:0] y);
        int mode = $urandom_range(0, 3);
        x = $urandom;
        y = $urandom;
        if (mode == 1) begin
            x = 32'($signed($urandom_range(0, 20)) - 10);
            y = 32'($signed($urandom_range(0, 20)) - 10);
        end else if (mode == 2) begin
            x = -32'($urandom_range(1, 100000));
            y = '0;
        end else if (mode == 3) begin
            x = '0;
        end
    endtask

    initial begin
        logic [31:0] rx, ry;
        repeat (3) @(negedge clk);
        total++;
        if (busy || done || theta != '0) begin
            bad++;
            $display("FAIL reset_state busy=%0b done=%0b theta=%0d required 0/0/0", busy, done, $signed(theta));
        end
        rst = 1'b1;
        @(negedge clk);
        run(32'd1000, 32'd0);
        run(32'd0, 32'd1000);
        run(-32'd1000, 32'd0);
        run(32'd1000, -32'd1000);
        run(32'h8000_0000, 32'h8000_0000);
        run(32'h7fff_ffff, 32'h7fff_ffff);
        run(32'd0, 32'd0);
        drive(1'b1, 32'd3, 32'd4);
        repeat (ITER + 3) drive(1'b1, 32'd0, 32'd1);
        wait_idle();
        drive(1'b1, 32'd100, 32'd200);
        repeat (ITER + 2) drive(1'b0, $urandom, $urandom);
        drive(1'b1, -32'd300, -32'd50);
        wait_idle();
        drive(1'b1, 32'd500, -32'd700);
        repeat (10) drive(1'b0, $urandom, $urandom);
        rst = 1'b0;
        #1;
        total++;
        if (busy || done || theta != '0) begin
            bad++;
            $display("FAIL mid_reset busy=%0b done=%0b theta=%0d required 0/0/0", busy, done, $signed(theta));
        end
        q.delete();
        held = '0;
        @(negedge clk);
        rst = 1'b1;
        repeat (ITER + 4) drive(1'b0, $urandom, $urandom);
        run(32'd1000, 32'd1000);
        repeat (1500) begin
            gen(rx, ry);
            drive($urandom_range(0, 3) == 0, rx, ry);
        end
        wait_idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
